// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (fetch/decode/execute sequencing, memory handshake).
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes and add Illegal_Instr_o.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       PC_Write_Cond_o,
    output logic       IR_Write_o,
    output logic       I_or_D_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       Reg_Write_o,
    output logic       Instr_Done_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [1:0] PC_Src_o,
    output logic [2:0] ALU_Op_o,
    output logic [3:0] State_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       Illegal_Instr_o
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JAL      = 4'd9,
        JALR     = 4'd10
`ifdef ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd15
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;

    state_t state;
    logic   op_known;

    assign op_known = OP_i inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_BR, OP_JAL, OP_JALR};
    assign State_o  = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (Mem_Ready_i) state <= DECODE;
                DECODE: begin
                    case (OP_i)
                        OP_LOAD, OP_STORE:   state <= MEM_ADDR;
                        OP_R, OP_I, OP_LUI:  state <= EXEC;
                        OP_BR:               state <= BRANCH;
                        OP_JAL:              state <= JAL;
                        OP_JALR:             state <= JALR;
`ifdef ILLEGAL_TRAP_EN
                        default:             state <= TRAP;
`else
                        default:             state <= FETCH;
`endif
                    endcase
                end
                MEM_ADDR: state <= (OP_i == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:   if (Mem_Ready_i) state <= MEM_WB;
                MEM_WR:   if (Mem_Ready_i) state <= FETCH;
                EXEC:     state <= ALU_WB;
`ifdef ILLEGAL_TRAP_EN
                TRAP:     state <= TRAP;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    // Outputs decode the state combinationally: FETCH/MEM_WR enables follow
    // Mem_Ready_i and reset must squash writes within the same cycle.
    always_comb begin
        PC_Write_o      = 1'b0;
        PC_Write_Cond_o = 1'b0;
        IR_Write_o      = 1'b0;
        I_or_D_o        = 1'b0;
        Mem_Read_o      = 1'b0;
        Mem_Write_o     = 1'b0;
        Reg_Write_o     = 1'b0;
        Instr_Done_o    = 1'b0;
        Mem_to_Reg_o    = 2'b00;
        ALU_Src_A_o     = 2'b00;
        ALU_Src_B_o     = 2'b00;
        PC_Src_o        = 2'b00;
        ALU_Op_o        = 3'b000;
`ifdef ILLEGAL_TRAP_EN
        Illegal_Instr_o = 1'b0;
`endif
        case (state)
            FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b011;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            DECODE: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b011;
`ifndef ILLEGAL_TRAP_EN
                Instr_Done_o = !op_known;
`endif
            end
            MEM_ADDR: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = (OP_i == OP_STORE) ? 3'b100 : 3'b011;
            end
            MEM_RD: begin
                Mem_Read_o = 1'b1;
                I_or_D_o   = 1'b1;
            end
            MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
                Instr_Done_o = 1'b1;
            end
            MEM_WR: begin
                Mem_Write_o  = 1'b1;
                I_or_D_o     = 1'b1;
                Instr_Done_o = Mem_Ready_i;
            end
            EXEC: begin
                ALU_Op_o    = (OP_i == OP_R) ? 3'b000 : (OP_i == OP_I) ? 3'b001 : 3'b010;
                ALU_Src_A_o = (OP_i == OP_LUI) ? 2'b11 : 2'b10;
                ALU_Src_B_o = (OP_i == OP_R) ? 2'b00 : 2'b10;
            end
            ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Instr_Done_o = 1'b1;
            end
            BRANCH: begin
                ALU_Src_A_o     = 2'b10;
                ALU_Op_o        = 3'b101;
                PC_Write_Cond_o = 1'b1;
                PC_Src_o        = 2'b01;
                Instr_Done_o    = 1'b1;
            end
            JAL: begin
                PC_Write_o   = 1'b1;
                PC_Src_o     = 2'b01;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                Instr_Done_o = 1'b1;
            end
            JALR: begin
                ALU_Src_A_o  = 2'b10;
                ALU_Src_B_o  = 2'b10;
                ALU_Op_o     = 3'b011;
                PC_Write_o   = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                Instr_Done_o = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: Illegal_Instr_o = 1'b1;
`endif
            default: ;
        endcase

        if (!reset) begin
            PC_Write_o      = 1'b0;
            PC_Write_Cond_o = 1'b0;
            IR_Write_o      = 1'b0;
            Reg_Write_o     = 1'b0;
            Mem_Write_o     = 1'b0;
            Mem_Read_o      = 1'b0;
            Instr_Done_o    = 1'b0;
            I_or_D_o        = 1'b0;
            Mem_to_Reg_o    = 2'b00;
            ALU_Src_A_o     = 2'b00;
            ALU_Src_B_o     = 2'b01;
            PC_Src_o        = 2'b00;
            ALU_Op_o        = 3'b011;
`ifdef ILLEGAL_TRAP_EN
            Illegal_Instr_o = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction state sequences
// from an opcode table, random memory stalls, latency arithmetic and reset cases.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] OP_i;
    logic       Mem_Ready_i;
    logic       PC_Write_o, PC_Write_Cond_o, IR_Write_o, I_or_D_o;
    logic       Mem_Read_o, Mem_Write_o, Reg_Write_o, Instr_Done_o;
    logic [1:0] Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, PC_Src_o;
    logic [2:0] ALU_Op_o;
    logic [3:0] State_o;
`ifdef ILLEGAL_TRAP_EN
    logic       Illegal_Instr_o;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    multicycle_control dut (
        .clk             (clk),
        .reset           (reset),
        .OP_i            (OP_i),
        .Mem_Ready_i     (Mem_Ready_i),
        .PC_Write_o      (PC_Write_o),
        .PC_Write_Cond_o (PC_Write_Cond_o),
        .IR_Write_o      (IR_Write_o),
        .I_or_D_o        (I_or_D_o),
        .Mem_Read_o      (Mem_Read_o),
        .Mem_Write_o     (Mem_Write_o),
        .Reg_Write_o     (Reg_Write_o),
        .Instr_Done_o    (Instr_Done_o),
        .Mem_to_Reg_o    (Mem_to_Reg_o),
        .ALU_Src_A_o     (ALU_Src_A_o),
        .ALU_Src_B_o     (ALU_Src_B_o),
        .PC_Src_o        (PC_Src_o),
        .ALU_Op_o        (ALU_Op_o),
        .State_o         (State_o)
`ifdef ILLEGAL_TRAP_EN
        ,
        .Illegal_Instr_o (Illegal_Instr_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected cycle count from the published latency figures plus stall cycles.
    function automatic int unsigned latency(input logic [6:0] op, input int unsigned fs,
                                            input int unsigned ms);
        case (op)
            7'h03:                return 5 + fs + ms;
            7'h23:                return 4 + fs + ms;
            7'h33, 7'h13, 7'h37:  return 4 + fs;
            7'h63, 7'h6F, 7'h67:  return 3 + fs;
            default:              return 2 + fs;
        endcase
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1 in the next FETCH.
    task automatic run_instr(input logic [6:0] op, input int unsigned fs, input int unsigned ms);
        int unsigned seq[$];
        int unsigned idx = 0, cnt = 0, cycles = 0, s, need;
        bit          rdy, adv, last, wait_st;
        case (op)
            7'h03:                seq = '{0, 1, 2, 3, 4};
            7'h23:                seq = '{0, 1, 2, 5};
            7'h33, 7'h13, 7'h37:  seq = '{0, 1, 6, 7};
            7'h63:                seq = '{0, 1, 8};
            7'h6F:                seq = '{0, 1, 9};
            7'h67:                seq = '{0, 1, 10};
            default:              seq = '{0, 1};
        endcase
        OP_i = op;
        while (idx < seq.size() && cycles < 64) begin
            s       = seq[idx];
            wait_st = (s == 0 || s == 3 || s == 5);
            need    = (s == 0) ? fs : (wait_st ? ms : 0);
            rdy     = wait_st ? (cnt >= need) : 1'($urandom_range(0, 1));
            Mem_Ready_i = rdy;
            #1;
            adv  = !wait_st || rdy;
            last = (idx == seq.size() - 1);
            check("state", 32'(State_o), s);
            check("instr_done", 32'(Instr_Done_o), 32'(last && adv));
            check("reg_write", 32'(Reg_Write_o), 32'(s == 4 || s == 7 || s == 9 || s == 10));
            check("mem_write", 32'(Mem_Write_o), 32'(s == 5));
            check("mem_read", 32'(Mem_Read_o), 32'(s == 0 || s == 3));
            check("ir_write", 32'(IR_Write_o), 32'(s == 0 && rdy));
            case (s)
                2: check("alu_op_addr", 32'(ALU_Op_o), (op == 7'h23) ? 32'd4 : 32'd3);
                3, 5: check("i_or_d", 32'(I_or_D_o), 32'd1);
                4: check("mem_to_reg_ld", 32'(Mem_to_Reg_o), 32'd1);
                6: begin
                    check("alu_op_exec", 32'(ALU_Op_o), (op == 7'h33) ? 0 : (op == 7'h13) ? 1 : 2);
                    check("src_a_exec", 32'(ALU_Src_A_o), (op == 7'h37) ? 32'd3 : 32'd2);
                    check("src_b_exec", 32'(ALU_Src_B_o), (op == 7'h33) ? 32'd0 : 32'd2);
                end
                7: check("mem_to_reg_alu", 32'(Mem_to_Reg_o), 32'd0);
                8: begin
                    check("pc_wr_cond", 32'(PC_Write_Cond_o), 32'd1);
                    check("alu_op_br", 32'(ALU_Op_o), 32'd5);
                    check("pc_src_br", 32'(PC_Src_o), 32'd1);
                end
                9: begin
                    check("mem_to_reg_jal", 32'(Mem_to_Reg_o), 32'd2);
                    check("pc_write_jal", 32'(PC_Write_o), 32'd1);
                    check("pc_src_jal", 32'(PC_Src_o), 32'd1);
                end
                10: begin
                    check("pc_write_jalr", 32'(PC_Write_o), 32'd1);
                    check("pc_src_jalr", 32'(PC_Src_o), 32'd0);
                    check("mem_to_reg_jalr", 32'(Mem_to_Reg_o), 32'd2);
                end
                default: ;
            endcase
            cycles++;
            @(posedge clk);
            #1;
            if (adv) begin
                idx++;
                cnt = 0;
            end else begin
                cnt++;
            end
        end
        check("latency", cycles, latency(op, fs, ms));
    endtask

    logic [6:0] ops[10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h00};

    initial begin
        int unsigned n_ops;
        reset       = 1'b0;
        Mem_Ready_i = 1'b1;
        OP_i        = 7'h00;

        // Reset held two cycles.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check("rst_state", 32'(State_o), 0);
            check("rst_mem_read", 32'(Mem_Read_o), 0);
            check("rst_ir_write", 32'(IR_Write_o), 0);
            check("rst_pc_write", 32'(PC_Write_o), 0);
            check("rst_reg_write", 32'(Reg_Write_o), 0);
            check("rst_src_b", 32'(ALU_Src_B_o), 1);
            check("rst_alu_op", 32'(ALU_Op_o), 3);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rel_state", 32'(State_o), 0);
        check("rel_mem_read", 32'(Mem_Read_o), 1);
        check("rel_ir_write", 32'(IR_Write_o), 1);
        Mem_Ready_i = 1'b0;
        @(posedge clk);
        #1;

        run_instr(7'h33, 0, 0);
        run_instr(7'h03, 0, 2);
        run_instr(7'h63, 0, 0);
        run_instr(7'h6F, 0, 0);
        run_instr(7'h23, 1, 3);

`ifdef ILLEGAL_TRAP_EN
        n_ops = 8;
`else
        n_ops = 10;
`endif
        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset landing in MEM_WR with memory ready must not commit the store.
        OP_i = 7'h23;
        Mem_Ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mw_state", 32'(State_o), 5);
        check("mw_write", 32'(Mem_Write_o), 1);
        reset = 1'b0;
        #1;
        check("mw_rst_write", 32'(Mem_Write_o), 0);
        check("mw_rst_done", 32'(Instr_Done_o), 0);
        @(posedge clk);
        #1;
        check("mw_rst_state", 32'(State_o), 0);
        reset = 1'b1;

        // Unknown opcode.
`ifdef ILLEGAL_TRAP_EN
        OP_i = 7'h7F;
        @(posedge clk);
        #1;
        check("ill_decode", 32'(State_o), 1);
        check("ill_done", 32'(Instr_Done_o), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            Mem_Ready_i = 1'($urandom_range(0, 1));
            #1;
            check("trap_state", 32'(State_o), 15);
            check("trap_flag", 32'(Illegal_Instr_o), 1);
            check("trap_pc_write", 32'(PC_Write_o), 0);
            check("trap_mem_read", 32'(Mem_Read_o), 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check("trap_rst_flag", 32'(Illegal_Instr_o), 0);
        @(posedge clk);
        #1;
        check("trap_rst_state", 32'(State_o), 0);
        reset = 1'b1;
`else
        Mem_Ready_i = 1'b0;
        @(posedge clk);
        #1;
        run_instr(7'h7F, 0, 0);
        #1;
        check("nop_back_fetch", 32'(State_o), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
